// File: rtl/uart_fifo_if.sv
// CPU-side I/O bus of the FIFO-buffered UART: strobed write/read, status and error flags.
interface uart_fifo_if;
    logic       wr;
    logic [7:0] tx_data;
    logic       tx_full;
    logic       busy;
    logic       rd;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       parity_err;
    logic       valid;
    logic       overrun;
    logic       err_clr;

    modport master (
        output wr, tx_data, rd, err_clr,
        input  tx_full, busy, rx_data, frame_err, parity_err, valid, overrun
    );

    modport slave (
        input  wr, tx_data, rd, err_clr,
        output tx_full, busy, rx_data, frame_err, parity_err, valid, overrun
    );
endinterface

// File: rtl/uart_fifo.sv
// FIFO-buffered UART with compile-time frame format, false-start rejection,
// per-entry framing/parity flags and a sticky RX overrun flag.
module uart_fifo #(
    parameter int DIVIDER   = 104,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    uart_fifo_if.slave bus
);
    // state | meaning
    // IDLE  | line idle, waiting for data (TX) or a start edge (RX)
    // START | start bit (RX: half-bit wait then validity check)
    // DATA  | data bits, LSB first
    // PARITY| parity bit, only reachable when PARITY != 0
    // STOP  | stop bit(s); RX leaves at mid first stop bit
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam int CW  = $clog2(DIVIDER);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int RW  = DATA_BITS + 2;
    localparam logic [CW-1:0] C_BIT       = CW'(DIVIDER - 1);
    localparam logic [CW-1:0] C_HALF      = CW'(DIVIDER / 2 - 1);
    localparam logic [2:0]    C_LAST      = 3'(DATA_BITS - 1);
    localparam logic          C_LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [7:0]    C_MASK      = 8'((1 << DATA_BITS) - 1);

    function automatic logic par_of(input logic [7:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    // ---------------- TX FIFO ----------------
    logic [7:0]   r_tx_mem [TX_DEPTH];
    logic [TAW:0] r_tx_wp, r_tx_rp;
    logic         w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
    logic [7:0]   w_tx_head;

    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[TAW] != r_tx_rp[TAW]) &&
                        (r_tx_wp[TAW-1:0] == r_tx_rp[TAW-1:0]);
    assign w_tx_push  = bus.wr && !w_tx_full;
    assign w_tx_head  = r_tx_mem[r_tx_rp[TAW-1:0]] & C_MASK;

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[TAW-1:0]] <= bus.tx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
        end
    end

    // ---------------- TX engine ----------------
    state_t          r_tx_state, w_tx_state_nxt;
    logic [CW-1:0]   r_tx_cnt;
    logic [2:0]      r_tx_bit;
    logic            r_tx_stop, r_tx_par;
    logic [7:0]      r_tx_shift;
    logic            w_tx_tick;

    assign w_tx_tick = (r_tx_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_tx_state <= S_IDLE;
        else       r_tx_state <= w_tx_state_nxt;
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        unique case (r_tx_state)
            S_IDLE:   if (!w_tx_empty) w_tx_state_nxt = S_START;
            S_START:  if (w_tx_tick) w_tx_state_nxt = S_DATA;
            S_DATA:   if (w_tx_tick && r_tx_bit == C_LAST)
                          w_tx_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_tx_tick) w_tx_state_nxt = S_STOP;
            S_STOP:   if (w_tx_tick && r_tx_stop == C_LAST_STOP)
                          w_tx_state_nxt = w_tx_empty ? S_IDLE : S_START;
            default:  w_tx_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_pop = (w_tx_state_nxt == S_START) && (r_tx_state != S_START);
        unique case (r_tx_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = r_tx_shift[0];
            S_PARITY: tx = r_tx_par;
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_stop  <= 1'b0;
            r_tx_par   <= 1'b0;
            r_tx_shift <= '0;
        end else begin
            if (w_tx_pop || w_tx_tick) r_tx_cnt <= C_BIT;
            else                       r_tx_cnt <= r_tx_cnt - 1'b1;
            if (w_tx_pop) begin
                r_tx_shift <= w_tx_head;
                r_tx_par   <= par_of(w_tx_head);
                r_tx_bit   <= '0;
                r_tx_stop  <= 1'b0;
            end else if (w_tx_tick) begin
                if (r_tx_state == S_DATA) begin
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_bit   <= r_tx_bit + 1'b1;
                end
                if (r_tx_state == S_STOP) r_tx_stop <= ~r_tx_stop;
            end
        end
    end

    assign bus.tx_full = w_tx_full;
    assign bus.busy    = !w_tx_empty || (r_tx_state != S_IDLE);

    // ---------------- RX engine ----------------
    logic                 r_rx_s1, r_rx_s2, r_rx_hold, r_rx_perr;
    state_t               r_rx_state, w_rx_state_nxt;
    logic [CW-1:0]        r_rx_cnt;
    logic [2:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 w_rx_tick, w_rx_push;

    assign w_rx_tick = (r_rx_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rx_state <= S_IDLE;
        else       r_rx_state <= w_rx_state_nxt;
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        unique case (r_rx_state)
            S_IDLE:   if (!r_rx_s2 && !r_rx_hold) w_rx_state_nxt = S_START;
            S_START:  if (w_rx_tick) w_rx_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:   if (w_rx_tick && r_rx_bit == C_LAST)
                          w_rx_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_rx_tick) w_rx_state_nxt = S_STOP;
            S_STOP:   if (w_rx_tick) w_rx_state_nxt = S_IDLE;
            default:  w_rx_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rx_push = (r_rx_state == S_STOP) && w_rx_tick;
    end

    // A low stop bit holds off new starts until the line is seen high, so a break yields one entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_perr  <= 1'b0;
            r_rx_shift <= '0;
            r_rx_hold  <= 1'b0;
        end else begin
            if (r_rx_state == S_IDLE) begin
                r_rx_cnt  <= C_HALF;
                r_rx_bit  <= '0;
                r_rx_perr <= 1'b0;
            end else begin
                r_rx_cnt <= w_rx_tick ? C_BIT : r_rx_cnt - 1'b1;
                if (r_rx_state == S_DATA && w_rx_tick) begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                    r_rx_bit   <= r_rx_bit + 1'b1;
                end
                if (r_rx_state == S_PARITY && w_rx_tick)
                    r_rx_perr <= (r_rx_s2 != par_of(8'(r_rx_shift)));
            end
            if (w_rx_push && !r_rx_s2)                    r_rx_hold <= 1'b1;
            else if (r_rx_state == S_IDLE && r_rx_s2)     r_rx_hold <= 1'b0;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [RW-1:0] r_rx_mem [RX_DEPTH];
    logic [RAW:0]  r_rx_wp, r_rx_rp;
    logic          r_overrun;
    logic          w_rx_empty, w_rx_full, w_rx_rd, w_rx_wr;
    logic [RW-1:0] w_rx_head;

    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[RAW] != r_rx_rp[RAW]) &&
                        (r_rx_wp[RAW-1:0] == r_rx_rp[RAW-1:0]);
    assign w_rx_rd    = bus.rd && !w_rx_empty;
    assign w_rx_wr    = w_rx_push && (!w_rx_full || w_rx_rd);
    assign w_rx_head  = r_rx_mem[r_rx_rp[RAW-1:0]];

    always_ff @(posedge clk) begin
        if (w_rx_wr) r_rx_mem[r_rx_wp[RAW-1:0]] <= {r_rx_perr, ~r_rx_s2, r_rx_shift};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_wp   <= '0;
            r_rx_rp   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_rx_wr) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_rd) r_rx_rp <= r_rx_rp + 1'b1;
            if (w_rx_push && w_rx_full && !w_rx_rd) r_overrun <= 1'b1;
            else if (bus.err_clr)                   r_overrun <= 1'b0;
        end
    end

    assign bus.valid      = !w_rx_empty;
    assign bus.rx_data    = w_rx_empty ? 8'h00 : 8'(w_rx_head[DATA_BITS-1:0]);
    assign bus.frame_err  = !w_rx_empty && w_rx_head[DATA_BITS];
    assign bus.parity_err = !w_rx_empty && w_rx_head[DATA_BITS+1];
    assign bus.overrun    = r_overrun;
endmodule
